// File: rtl/msg_frame_scheduler.sv
// Round-robin framer: for each sensor channel emits a header beat and the channel's FIFO bytes
// packed MSB-lane first into OUT_W-bit upstream beats. Optional build macro: MSG_SKIP_EMPTY_EN.
module msg_frame_scheduler #(
  parameter int CH_NUM = 20,
  parameter int OUT_W  = 128,
  parameter int LEN_W  = 16
) (
  input  logic                    sys_clk_i,
  input  logic                    rst_n_i,
  input  logic                    start_pulse_i,
  input  logic [7:0]              msg_id_i,
  input  logic [CH_NUM*24-1:0]    sensor_id_i,
  output logic [CH_NUM-1:0]       rd_en_o,
  input  logic [CH_NUM*8-1:0]     din_i,
  input  logic [CH_NUM*LEN_W-1:0] data_count_i,
  input  logic [CH_NUM-1:0]       empty_i,
  output logic                    us_wr_en_o,
  output logic [OUT_W-1:0]        us_wr_dout_o,
  input  logic                    us_prog_full_i,
  output logic                    busy_o,
  output logic                    round_done_o
);

  localparam int NB    = OUT_W / 8;
  localparam int PC_W  = $clog2(NB + 1);
  localparam int IDX_W = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
  localparam int CNT_W = $clog2(CH_NUM + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SELECT, S_HEADER, S_PAYLOAD, S_FLUSH, S_DONE
  } state_t;

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   ch_reg, ch_next;
  logic [LEN_W-1:0]   rd_cnt_reg, rd_cnt_next;
  logic [OUT_W-1:0]   pack_reg, pack_next;
  logic [PC_W-1:0]    pack_cnt_reg, pack_cnt_next;
  logic               inflight_reg, sub_reg;
  logic               wr_en_reg, wr_en_next;
  logic [OUT_W-1:0]   dout_reg, dout_next;
  logic [15:0]        frame_reg, frame_next;
  logic               busy_reg, busy_next;
  logic               done_reg, done_next;
  logic               issue;
  logic               latch_en;

  logic [LEN_W-1:0]   cnt_arr [CH_NUM];
  logic [23:0]        sid_arr [CH_NUM];
  logic [7:0]         din_arr [CH_NUM];

  logic [IDX_W-1:0]   ch_sel;
  logic [LEN_W-1:0]   cur_len;
  logic [15:0]        len16;
  logic [23:0]        cur_sid;
  logic               cur_empty;
  logic [7:0]         land_byte;
  logic [127:0]       hdr;

  // Per-channel configuration is captured once per round so mid-round input changes are harmless.
  genvar gi;
  generate
    for (gi = 0; gi < CH_NUM; gi++) begin : g_ch
      logic [LEN_W-1:0] cnt_q;
      logic [23:0]      sid_q;

      always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
          cnt_q <= '0;
          sid_q <= '0;
        end else if (latch_en) begin
          cnt_q <= data_count_i[gi*LEN_W +: LEN_W];
          sid_q <= sensor_id_i[gi*24 +: 24];
        end
      end

      assign cnt_arr[gi] = cnt_q;
      assign sid_arr[gi] = sid_q;
      assign din_arr[gi] = din_i[gi*8 +: 8];
      assign rd_en_o[gi] = issue && !cur_empty && (ch_sel == IDX_W'(gi));
    end

    if (LEN_W >= 16) begin : g_len_trunc
      assign len16 = cur_len[15:0];
    end else begin : g_len_ext
      assign len16 = {{(16 - LEN_W){1'b0}}, cur_len};
    end
  endgenerate

  assign ch_sel    = ch_reg[IDX_W-1:0];
  assign cur_len   = cnt_arr[ch_sel];
  assign cur_sid   = sid_arr[ch_sel];
  assign cur_empty = empty_i[ch_sel];
  assign land_byte = sub_reg ? 8'h00 : din_arr[ch_sel];
  assign hdr       = {32'hFDF7_EB90, 4'h1, frame_reg, msg_id_i, cur_sid, len16, 28'h0};

  always_comb begin
    state_next    = state_reg;
    ch_next       = ch_reg;
    rd_cnt_next   = rd_cnt_reg;
    pack_next     = pack_reg;
    pack_cnt_next = pack_cnt_reg;
    wr_en_next    = 1'b0;
    dout_next     = dout_reg;
    frame_next    = frame_reg;
    busy_next     = busy_reg;
    done_next     = 1'b0;
    issue         = 1'b0;
    latch_en      = 1'b0;

    // A read issued last cycle lands now; issue gating guarantees a free lane for it.
    if (inflight_reg) begin
      for (int i = 0; i < NB; i++) begin
        if (pack_cnt_reg == PC_W'(i)) pack_next[OUT_W-1-8*i -: 8] = land_byte;
      end
      pack_cnt_next = pack_cnt_reg + 1'b1;
    end

    case (state_reg)
      S_IDLE: begin
        if (start_pulse_i) begin
          latch_en   = 1'b1;
          busy_next  = 1'b1;
          ch_next    = '0;
          state_next = S_SELECT;
        end
      end

      S_SELECT: begin
        rd_cnt_next = '0;
        if (ch_reg == CNT_W'(CH_NUM)) state_next = S_DONE;
`ifdef MSG_SKIP_EMPTY_EN
        else if (cur_len == '0) ch_next = ch_reg + 1'b1;
`endif
        else state_next = S_HEADER;
      end

      S_HEADER: begin
        if (!us_prog_full_i) begin
          wr_en_next             = 1'b1;
          dout_next              = '0;
          dout_next[OUT_W-1 -: 128] = hdr;
          state_next             = S_PAYLOAD;
        end
      end

      S_PAYLOAD: begin
        issue = !us_prog_full_i && (rd_cnt_reg < cur_len) &&
                ((pack_cnt_reg + PC_W'(inflight_reg)) < PC_W'(NB));
        if (issue) rd_cnt_next = rd_cnt_reg + 1'b1;
        if (pack_cnt_reg == PC_W'(NB)) begin
          if (!us_prog_full_i) begin
            wr_en_next    = 1'b1;
            dout_next     = pack_reg;
            pack_next     = '0;
            pack_cnt_next = '0;
          end
        end else if ((rd_cnt_reg == cur_len) && !inflight_reg) begin
          state_next = S_FLUSH;
        end
      end

      S_FLUSH: begin
        if (pack_cnt_reg == '0) begin
          ch_next    = ch_reg + 1'b1;
          state_next = S_SELECT;
        end else if (!us_prog_full_i) begin
          wr_en_next    = 1'b1;
          dout_next     = pack_reg;
          pack_next     = '0;
          pack_cnt_next = '0;
          ch_next       = ch_reg + 1'b1;
          state_next    = S_SELECT;
        end
      end

      S_DONE: begin
        frame_next = frame_reg + 16'd1;
        busy_next  = 1'b0;
        done_next  = 1'b1;
        state_next = S_IDLE;
      end

      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_reg    <= S_IDLE;
      ch_reg       <= '0;
      rd_cnt_reg   <= '0;
      pack_reg     <= '0;
      pack_cnt_reg <= '0;
      inflight_reg <= 1'b0;
      sub_reg      <= 1'b0;
      wr_en_reg    <= 1'b0;
      dout_reg     <= '0;
      frame_reg    <= '0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      ch_reg       <= ch_next;
      rd_cnt_reg   <= rd_cnt_next;
      pack_reg     <= pack_next;
      pack_cnt_reg <= pack_cnt_next;
      inflight_reg <= issue;
      sub_reg      <= issue && cur_empty;
      wr_en_reg    <= wr_en_next;
      dout_reg     <= dout_next;
      frame_reg    <= frame_next;
      busy_reg     <= busy_next;
      done_reg     <= done_next;
    end
  end

  assign us_wr_en_o   = wr_en_reg;
  assign us_wr_dout_o = dout_reg;
  assign busy_o       = busy_reg;
  assign round_done_o = done_reg;

endmodule

// File: tb/tb_msg_frame_scheduler.sv
// Scoreboard bench for msg_frame_scheduler: FIFO models per channel, expected beats queued at round start.
module tb_msg_frame_scheduler;

  localparam int CH = 4;
  localparam int OW = 128;
  localparam int LW = 16;
  localparam int NB = OW / 8;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic            start = 1'b0;
  logic [7:0]      msg_id = 8'h5A;
  logic [CH*24-1:0] sensor_id = '0;
  logic [CH-1:0]   rd_en;
  logic [CH*8-1:0] din = '0;
  logic [CH*LW-1:0] data_count = '0;
  logic [CH-1:0]   empty;
  logic            wr_en;
  logic [OW-1:0]   wr_dout;
  logic            prog_full = 1'b0;
  logic            busy;
  logic            round_done;

  always #5 clk = ~clk;

  msg_frame_scheduler #(.CH_NUM(CH), .OUT_W(OW), .LEN_W(LW)) dut (
    .sys_clk_i      (clk),
    .rst_n_i        (rst_n),
    .start_pulse_i  (start),
    .msg_id_i       (msg_id),
    .sensor_id_i    (sensor_id),
    .rd_en_o        (rd_en),
    .din_i          (din),
    .data_count_i   (data_count),
    .empty_i        (empty),
    .us_wr_en_o     (wr_en),
    .us_wr_dout_o   (wr_dout),
    .us_prog_full_i (prog_full),
    .busy_o         (busy),
    .round_done_o   (round_done)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [OW-1:0] got, input logic [OW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Per-channel FIFO model with one-cycle read latency
  logic [7:0] fifo_mem [CH][256];
  int         rd_ptr [CH] = '{default: 0};
  int         wr_ptr [CH] = '{default: 0};

  always @(posedge clk) begin
    for (int c = 0; c < CH; c++) begin
      if (rd_en[c]) begin
        din[c*8 +: 8] <= fifo_mem[c][rd_ptr[c] % 256];
        rd_ptr[c]     <= rd_ptr[c] + 1;
      end
    end
  end

  always_comb begin
    empty = '0;
    for (int c = 0; c < CH; c++) empty[c] = (rd_ptr[c] == wr_ptr[c]);
  end

  // 3 cycles asserted, 2 released while enabled
  bit pf_toggle = 1'b0;
  int pf_phase  = 0;
  always @(negedge clk) begin
    if (pf_toggle) begin
      prog_full = (pf_phase < 3);
      pf_phase  = (pf_phase + 1) % 5;
    end else begin
      prog_full = 1'b0;
    end
  end

  // Output monitor and scoreboard
  logic [OW-1:0] sb_q [$];
  int beats_seen = 0, rd_seen = 0, done_seen = 0, onehot_err = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if ($countones(rd_en) > 1) onehot_err++;
      rd_seen += $countones(rd_en);
      if (round_done) done_seen++;
      if (wr_en) begin
        beats_seen++;
        if (sb_q.size() == 0) begin
          check("beat_unexpected", OW'(sb_q.size()), OW'(1));
        end else begin
          check("beat", wr_dout, sb_q.pop_front());
          $display("beat %0d data=%h", beats_seen, wr_dout);
        end
      end
    end
  end

  int          cnt [CH];
  logic [23:0] sid [CH];
  logic [15:0] exp_frame = 16'h0000;

  task automatic load(input int c, input int n, input int base);
    for (int i = 0; i < n; i++) fifo_mem[c][(wr_ptr[c] + i) % 256] = 8'(base + i);
    wr_ptr[c] += n;
  endtask

  task automatic drive_cfg();
    for (int c = 0; c < CH; c++) begin
      data_count[c*LW +: LW] = LW'(cnt[c]);
      sensor_id[c*24 +: 24]  = sid[c];
    end
  endtask

  task automatic build_round(output int exp_beats, output int exp_rd);
    logic [OW-1:0] beat;
    logic [15:0]   len16;
    logic [7:0]    b;
    int            avail;
    exp_beats = 0;
    exp_rd    = 0;
    for (int c = 0; c < CH; c++) begin
`ifdef MSG_SKIP_EMPTY_EN
      if (cnt[c] == 0) continue;
`endif
      len16 = 16'(cnt[c]);
      sb_q.push_back({32'hFDF7EB90, 4'h1, exp_frame, msg_id, sid[c], len16, 28'h0});
      exp_beats++;
      avail = wr_ptr[c] - rd_ptr[c];
      beat  = '0;
      for (int i = 0; i < cnt[c]; i++) begin
        b = (i < avail) ? fifo_mem[c][(rd_ptr[c] + i) % 256] : 8'h00;
        beat[OW-1-8*(i % NB) -: 8] = b;
        if ((i % NB) == NB - 1 || i == cnt[c] - 1) begin
          sb_q.push_back(beat);
          exp_beats++;
          beat = '0;
        end
      end
      exp_rd += (cnt[c] < avail) ? cnt[c] : avail;
    end
    exp_frame = exp_frame + 16'd1;
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic run_round(input bit poke_start);
    int eb, er;
    drive_cfg();
    build_round(eb, er);
    beats_seen = 0; rd_seen = 0; done_seen = 0; onehot_err = 0;
    pulse_start();
    check("busy_after_start", OW'(busy), OW'(1));
    if (poke_start) begin
      repeat (6) @(negedge clk);
      for (int c = 0; c < CH; c++) data_count[c*LW +: LW] = LW'(cnt[c] + 7);
      start = 1'b1;
      @(negedge clk) start = 1'b0;
    end
    for (int i = 0; i < 4000 && done_seen == 0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    check("round_done_cnt", OW'(done_seen), OW'(1));
    check("beat_cnt", OW'(beats_seen), OW'(eb));
    check("rd_en_cnt", OW'(rd_seen), OW'(er));
    check("rd_en_onehot", OW'(onehot_err), OW'(0));
    check("sb_left", OW'(sb_q.size()), OW'(0));
    check("busy_idle", OW'(busy), OW'(0));
    $display("round complete: beats=%0d reads=%0d", beats_seen, rd_seen);
  endtask

  initial begin
    int eb, er;
    for (int c = 0; c < CH; c++) sid[c] = 24'(24'hD01000 + 24'h010101 * c);

    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_wr_en", OW'(wr_en), OW'(0));
    check("rst_dout", wr_dout, '0);
    check("rst_rd_en", OW'(rd_en), OW'(0));
    check("rst_busy", OW'(busy), OW'(0));
    check("rst_done", OW'(round_done), OW'(0));
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Mixed lengths, with an ignored start pulse mid-round
    cnt = '{16, 0, 5, 32};
    load(0, 16, 'h10); load(2, 5, 'h01); load(3, 32, 'h40);
    run_round(1'b1);

    // 64-byte channel under toggling back-pressure
    cnt = '{64, 0, 0, 0};
    load(0, 64, 'h00);
    pf_toggle = 1'b1;
    run_round(1'b0);
    pf_toggle = 1'b0;

    // FIFO runs dry after 3 of 8 bytes
    cnt = '{8, 0, 0, 0};
    load(0, 3, 'hAA);
    run_round(1'b0);

    // Frame counter wrap: jump straight to FFFF
    @(negedge clk) force dut.frame_reg = 16'hFFFF;
    @(negedge clk) release dut.frame_reg;
    exp_frame = 16'hFFFF;
    cnt = '{2, 0, 0, 0};
    load(0, 2, 'h77);
    run_round(1'b0);
    load(0, 2, 'h88);
    run_round(1'b0);

    // Reset in the middle of a payload
    cnt = '{32, 0, 0, 0};
    load(0, 32, 'h20);
    drive_cfg();
    build_round(eb, er);
    beats_seen = 0; rd_seen = 0; done_seen = 0; onehot_err = 0;
    pulse_start();
    for (int i = 0; i < 200 && rd_seen < 10; i++) @(negedge clk);
    check("pre_reset_reads", OW'(rd_seen >= 10), OW'(1));
    #2 rst_n = 1'b0;
    #1;
    check("midrst_wr_en", OW'(wr_en), OW'(0));
    check("midrst_dout", wr_dout, '0);
    check("midrst_rd_en", OW'(rd_en), OW'(0));
    check("midrst_busy", OW'(busy), OW'(0));
    check("midrst_done", OW'(round_done), OW'(0));
    sb_q.delete();
    exp_frame = 16'h0000;
    for (int c = 0; c < CH; c++) wr_ptr[c] = rd_ptr[c];
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Fresh round after reset starts at channel 0 with frame 0
    cnt = '{3, 1, 0, 0};
    load(0, 3, 'hC0); load(1, 1, 'hE1);
    run_round(1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/msg_frame_scheduler.md
MSG_FRAME_SCHEDULER -- requirements
Module: msg_frame_scheduler

Interface
REQ-001 Parameter CH_NUM, default 20: number of sensor channels, range 1..64.
REQ-002 Parameter OUT_W, default 128: output beat width in bits, a multiple of 8 and at least 128.
REQ-003 Parameter LEN_W, default 16: width of each per-channel byte count.
REQ-004 Ports, one per line (name, direction, width, meaning):
- sys_clk_i  in  1  the single clock; all logic is on its rising edge.
- rst_n_i  in  1  reset, asynchronous assert, active-low.
- start_pulse_i  in  1  one-cycle request to start a round.
- msg_id_i  in  8  source ID placed in every header.
- sensor_id_i  in  CH_NUM*24  per channel {des[23:16], dtype[15:8], chan[7:0]}.
- rd_en_o  out  CH_NUM  per-channel FIFO read strobe.
- din_i  in  CH_NUM*8  per-channel FIFO byte, valid 1 cycle after rd_en.
- data_count_i  in  CH_NUM*LEN_W  per-channel byte count.
- empty_i  in  CH_NUM  per-channel FIFO empty.
- us_wr_en_o  out  1  upstream write strobe.
- us_wr_dout_o  out  OUT_W  upstream beat.
- us_prog_full_i  in  1  upstream back-pressure.
- busy_o  out  1  high while a round is in progress.
- round_done_o  out  1  one-cycle pulse when a round completes.

Function
REQ-005 On start_pulse_i in IDLE, latch all data_count_i and sensor_id_i fields, assert busy_o on the next cycle, and go to SELECT with channel index 0.
REQ-006 start_pulse_i while busy_o=1 shall be ignored, and no latched value shall change.
REQ-007 States: IDLE -> SELECT -> HEADER -> PAYLOAD -> FLUSH -> SELECT(next) -> ... -> DONE -> IDLE.
REQ-008 SELECT shall take 1 cycle per channel; after the last channel the FSM goes to DONE.
REQ-009 HEADER shall emit one beat. Bits [OUT_W-1 -: 128] = {32'hFDF7_EB90, 4'h1, frame_cnt[15:0], msg_id, des, dtype, chan, len[15:0], 28'h0}. All lower bits are 0. len is the latched count zero-extended or truncated to 16 bits.
REQ-010 PAYLOAD shall read exactly len bytes from the current channel. Bytes pack MSB-lane first (byte 0 goes to bits [OUT_W-1:OUT_W-8]), giving OUT_W/8 bytes per beat.
REQ-011 A partial last beat shall be zero-padded and emitted in FLUSH. Beat count = 1 + ceil(len/(OUT_W/8)).
REQ-012 Read latency is 1 cycle: the byte sampled at t+1 belongs to rd_en_o asserted at t. At most one rd_en_o bit is high per cycle.
REQ-013 If empty_i of the current channel is 1 when a read is due, the block shall not assert rd_en_o and shall substitute byte 8'h00. The byte total still equals len.
REQ-014 While us_prog_full_i=1, no new rd_en_o or header beat shall issue; reads already issued still land and pack.
REQ-015 A full beat awaiting write shall be held with us_wr_en_o=0 until us_prog_full_i=0; no data is lost or duplicated.
REQ-016 us_wr_en_o shall be registered, and us_wr_dout_o shall be valid in the same cycle.
REQ-017 The 16-bit frame_cnt shall increment in DONE and wrap from 16'hFFFF to 0; the header uses the pre-increment value.
REQ-018 DONE shall pulse round_done_o for 1 cycle, deassert busy_o, and return to IDLE.

Reset
REQ-019 rst_n_i=0 shall immediately clear the FSM to IDLE, frame_cnt to 0, rd_en_o, us_wr_en_o, us_wr_dout_o, busy_o and round_done_o to 0, and all packing state. This applies mid-round; a partial beat is discarded.

Configuration
REQ-020 Macro MSG_SKIP_EMPTY_EN: when defined, a channel with latched count 0 emits nothing and costs 1 SELECT cycle. When undefined, it emits a header-only beat with len=0.

Verification
REQ-021 The bench shall cover these directed scenarios:
- CH_NUM=4, counts {16,0,5,32}, no MSG_SKIP_EMPTY_EN, prog_full=0 -> beats 2,1,2,3; header frame_cnt=0; round_done_o once.
- Same stimulus with MSG_SKIP_EMPTY_EN -> channel 1 emits no beat; 7 beats total.
- len=5, bytes 01..05 -> payload beat = 0x0102030405 followed by 88 zero bits.
- Toggle us_prog_full_i 3 cycles on / 2 off during a 64-byte channel -> output is 4 payload beats with bytes 00..3F in order, none duplicated.
- empty_i=1 after 3 of 8 bytes -> 3 real bytes then 5 zero bytes, rd_en_o count = 3.
- Preload frame_cnt=16'hFFFF via 65535 empty rounds, then a further round -> header shows FFFF and the next shows 0000. Also: rst_n_i low mid-payload -> all outputs 0 within the same cycle, and the next start begins with channel 0.
